// File: rtl/operand_feeder_pkg.sv
// Shared definitions for the operand feeder: FSM state encoding, store-select
// constants and the width helpers used to size the write address and the lane
// pointers.
package operand_feeder_pkg;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } feeder_state_e;

   localparam logic A_SEL = 1'b0;
   localparam logic B_SEL = 1'b1;

   // Write-address width: enough to address the larger of the two stores.
   function automatic int calc_aw(input int n, input int m, input int k);
      int depth;
      depth = ((n > m) ? n : m) * k;
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Lane pointer width: must hold 0..K inclusive (K means exhausted).
   function automatic int calc_pw(input int k);
      return (k < 1) ? 1 : $clog2(k + 1);
   endfunction

endpackage

// File: rtl/operand_feeder_lane.sv
// One streaming lane of the operand feeder.
// Ports:
//   clk, rst   clock / async active-high reset
//   clr        clear the pointer (stream (re)start accepted)
//   active     feeder is in STREAM
//   en         lane enable from the array controller
//   row        the K operands of this lane, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data       element at the current pointer while enabled, otherwise 0
//   done_next  pointer will be at K after this clock edge
//   ovr        enable seen while the lane is already exhausted (pulse)
module feeder_lane #(
   parameter int DATA_WIDTH = 32,
   parameter int K          = 3,
   parameter int PW         = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    active,
   input  logic                    en,
   input  logic [K*DATA_WIDTH-1:0] row,
   output logic [DATA_WIDTH-1:0]   data,
   output logic                    done_next,
   output logic                    ovr
);

   localparam logic [PW-1:0] PTR_END = PW'(K);

   logic [PW-1:0] ptr_q, ptr_d;
   logic          exhausted;
   logic          take;

   assign exhausted = (ptr_q == PTR_END);
   assign take      = active & en & ~exhausted;
   assign ovr       = active & en & exhausted;

   // Explicit compare per element so an exhausted pointer (== K) never indexes
   // past the row.
   always_comb begin
      data = '0;
      for (int k = 0; k < K; k++) begin
         if (take && (ptr_q == PW'(k))) data = row[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (clr)       ptr_d = '0;
      else if (take) ptr_d = ptr_q + 1'b1;
   end

   // Looking at the next pointer lets the FSM reach DONE on the very edge that
   // closes the final enable cycle.
   assign done_next = (ptr_d == PTR_END);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/operand_feeder.sv
// Operand source for the 3x3 systolic MAC array. Holds one A (N x K) and one
// B (K x M) matrix and streams them lane by lane on the array controller's
// per-lane enables.
// Ports:
//   clk, rst   clock / async active-high reset
//   wr_en, wr_sel, wr_addr, wr_data
//              operand write port (sel 0 = A at row*K+k, 1 = B at k*M+col)
//   start      pulse: begin (or repeat) streaming
//   a_en, b_en per-lane enables from the array controller
//   a_data     A lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_data     B lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   finished   every lane has delivered K elements (level, while in DONE)
//   busy       streaming
//   overrun    sticky: enable seen on an exhausted lane
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_LOAD   | stores writable, outputs 0, waiting for start
// ST_STREAM | lanes answer enables, writes and start ignored
// ST_DONE   | all lanes exhausted, finished=1; start restreams, wr_en loads
module operand_feeder
   import operand_feeder_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int N          = 3,
   parameter  int M          = 3,
   parameter  int K          = 3,
   localparam int AW         = calc_aw(N, M, K)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic                    wr_sel,
   input  logic [AW-1:0]           wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    start,
   input  logic [N-1:0]            a_en,
   input  logic [M-1:0]            b_en,
   output logic [N*DATA_WIDTH-1:0] a_data,
   output logic [M*DATA_WIDTH-1:0] b_data,
   output logic                    finished,
   output logic                    busy,
   output logic                    overrun
);

   localparam int            PW      = calc_pw(K);
   localparam logic [AW:0]   A_DEPTH = (AW+1)'(N*K);
   localparam logic [AW:0]   B_DEPTH = (AW+1)'(K*M);

   feeder_state_e state_q, state_d;
   logic          overrun_q, overrun_d;
   logic          clr;
   logic          active;
   logic          wr_ok;

   logic [DATA_WIDTH-1:0]   a_mem [N*K];
   logic [DATA_WIDTH-1:0]   b_mem [K*M];
   logic [K*DATA_WIDTH-1:0] a_row [N];
   logic [K*DATA_WIDTH-1:0] b_row [M];
   logic [N-1:0]            a_dn, a_ovr;
   logic [M-1:0]            b_dn, b_ovr;

   assign active = (state_q == ST_STREAM);
   assign wr_ok  = wr_en & ~active;

   // Stores carry no reset; contents are meaningful only once written.
   always_ff @(posedge clk) begin
      if (wr_ok && (wr_sel == A_SEL) && ({1'b0, wr_addr} < A_DEPTH)) a_mem[wr_addr] <= wr_data;
      if (wr_ok && (wr_sel == B_SEL) && ({1'b0, wr_addr} < B_DEPTH)) b_mem[wr_addr] <= wr_data;
   end

   for (genvar i = 0; i < N; i++) begin : g_a_lane
      for (genvar k = 0; k < K; k++) begin : g_a_elem
         assign a_row[i][k*DATA_WIDTH +: DATA_WIDTH] = a_mem[i*K + k];
      end
      feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .K(K), .PW(PW)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .clr       (clr),
         .active    (active),
         .en        (a_en[i]),
         .row       (a_row[i]),
         .data      (a_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .done_next (a_dn[i]),
         .ovr       (a_ovr[i])
      );
   end

   // B lanes walk a column, so element k of lane j sits at k*M + j.
   for (genvar j = 0; j < M; j++) begin : g_b_lane
      for (genvar k = 0; k < K; k++) begin : g_b_elem
         assign b_row[j][k*DATA_WIDTH +: DATA_WIDTH] = b_mem[k*M + j];
      end
      feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .K(K), .PW(PW)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .clr       (clr),
         .active    (active),
         .en        (b_en[j]),
         .row       (b_row[j]),
         .data      (b_data[j*DATA_WIDTH +: DATA_WIDTH]),
         .done_next (b_dn[j]),
         .ovr       (b_ovr[j])
      );
   end

   // start wins over wr_en for the state; the write itself still lands.
   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            if (start) begin
               state_d = ST_STREAM;
               clr     = 1'b1;
            end
         end
         ST_STREAM: begin
            if ((&a_dn) && (&b_dn)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_STREAM;
               clr     = 1'b1;
            end else if (wr_en) begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   assign overrun_d = overrun_q | (|a_ovr) | (|b_ovr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         overrun_q <= overrun_d;
      end
   end

   assign finished = (state_q == ST_DONE);
   assign busy     = active;
   assign overrun  = overrun_q;

endmodule
